// File: rtl/axicb_pkg.sv
// Shared crossbar helpers: RID-to-master routing and outstanding-counter sizing.
// Latency: pure functions, no state.
// Backpressure: not applicable (no handshakes in this package).
//
// Used by both the read and write slave-side switches so that routing and
// counter sizing stay identical between the two directions.
package axicb_pkg;

    localparam int AXICB_MAX_MST  = 4;
    localparam int AXICB_MAX_ID_W = 32;

    // Width of a counter that must hold values 0..ostd_num inclusive.
    function automatic int ostd_cnt_w(input int ostd_num);
        return $clog2(ostd_num + 1);
    endfunction

    // One-hot owner of an ID. A master owns the ID when every bit of its tag
    // is set in the ID. Several tags can match the same ID (e.g. 'h30 also
    // contains 'h10 and 'h20), so the lowest index wins to keep the result
    // one-hot. All-zero result means nobody owns the ID.
    function automatic logic [AXICB_MAX_MST-1:0] rid_route(
        input logic [AXICB_MAX_ID_W-1:0] rid,
        input logic [AXICB_MAX_ID_W-1:0] mask0,
        input logic [AXICB_MAX_ID_W-1:0] mask1,
        input logic [AXICB_MAX_ID_W-1:0] mask2,
        input logic [AXICB_MAX_ID_W-1:0] mask3,
        input int                        mst_nb
    );
        logic [AXICB_MAX_MST-1:0] sel;
        sel = '0;
        if (mst_nb > 0 && (rid & mask0) == mask0)
            sel = 4'b0001;
        else if (mst_nb > 1 && (rid & mask1) == mask1)
            sel = 4'b0010;
        else if (mst_nb > 2 && (rid & mask2) == mask2)
            sel = 4'b0100;
        else if (mst_nb > 3 && (rid & mask3) == mask3)
            sel = 4'b1000;
        return sel;
    endfunction

endpackage

// File: rtl/axicb_round_robin.sv
// Priority-aware round-robin arbiter: highest priority level wins, rotation among equals.
// Latency: grant is combinational from req; rotation pointer updates on the enabled cycle.
// Backpressure: none; the caller samples grant only when it asserts en.
//
// Ports: aclk/srst clock and sync active-high reset; en advances the rotation
// when any request is present; req per-requester request; grant one-hot result.
module axicb_round_robin #(
    parameter int REQ_NB        = 4,
    parameter int REQ0_PRIORITY = 0,
    parameter int REQ1_PRIORITY = 0,
    parameter int REQ2_PRIORITY = 0,
    parameter int REQ3_PRIORITY = 0
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic              en,
    input  logic [REQ_NB-1:0] req,
    output logic [REQ_NB-1:0] grant
);

    localparam int IDX_W    = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;
    localparam int PRIO [4] = '{REQ0_PRIORITY, REQ1_PRIORITY, REQ2_PRIORITY, REQ3_PRIORITY};

    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  grant_idx;
    logic [REQ_NB-1:0] eligible;

    // Only requesters sitting at the highest requested priority level compete.
    always_comb begin : elig_blk
        int max_prio;
        max_prio = 0;
        eligible = '0;
        for (int i = 0; i < REQ_NB; i++)
            if (req[i] && PRIO[i] > max_prio)
                max_prio = PRIO[i];
        for (int i = 0; i < REQ_NB; i++)
            eligible[i] = req[i] && (PRIO[i] == max_prio);
    end

    // Search starts just after the last winner, so after reset (pointer at
    // the top index) requester 0 is served first.
    always_comb begin : pick_blk
        logic             found;
        logic [IDX_W-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        grant     = '0;
        grant_idx = last_idx;
        for (int k = 1; k <= REQ_NB; k++) begin
            idx = IDX_W'((int'(last_idx) + k) % REQ_NB);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (srst)
            last_idx <= IDX_W'(REQ_NB - 1);
        else if (en && |req)
            last_idx <= grant_idx;
    end

endmodule

// File: rtl/axicb_mst_switch_rd.sv
// Slave-side read switch: arbitrates up to four master AR channels onto one slave and routes R back by RID.
// Latency: AR one cycle from request to o_arvalid (one AR per two cycles max); R path combinational.
// Backpressure: o_arready passes to the granted master only; o_rready follows the owning master's ready, unowned beats are always accepted.
//
// Ports: aclk/srst clock and sync active-high reset; i_ar* per-master AR
// (payload of master i at [i*ARCH_W+:ARCH_W]); i_r* per-master valid/ready
// with broadcast rlast/payload; o_ar*/o_r* the single slave-side interface.
module axicb_mst_switch_rd
    import axicb_pkg::*;
#(
    parameter int                  AXI_ID_W      = 8,
    parameter int                  MST_NB        = 4,
    parameter logic [AXI_ID_W-1:0] MST0_ID_MASK  = 'h10,
    parameter logic [AXI_ID_W-1:0] MST1_ID_MASK  = 'h20,
    parameter logic [AXI_ID_W-1:0] MST2_ID_MASK  = 'h30,
    parameter logic [AXI_ID_W-1:0] MST3_ID_MASK  = 'h40,
    parameter int                  MST0_PRIORITY = 0,
    parameter int                  MST1_PRIORITY = 0,
    parameter int                  MST2_PRIORITY = 0,
    parameter int                  MST3_PRIORITY = 0,
    parameter int                  OSTDREQ_NUM   = 4,
    parameter int                  ARCH_W        = 8,
    parameter int                  RCH_W         = 8
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic [MST_NB-1:0]        i_arvalid,
    output logic [MST_NB-1:0]        i_arready,
    input  logic [MST_NB*ARCH_W-1:0] i_arch,
    output logic [MST_NB-1:0]        i_rvalid,
    input  logic [MST_NB-1:0]        i_rready,
    output logic                     i_rlast,
    output logic [RCH_W-1:0]         i_rch,
    output logic                     o_arvalid,
    input  logic                     o_arready,
    output logic [ARCH_W-1:0]        o_arch,
    input  logic                     o_rvalid,
    output logic                     o_rready,
    input  logic                     o_rlast,
    input  logic [RCH_W-1:0]         o_rch
);

    localparam int CNT_W = ostd_cnt_w(OSTDREQ_NUM);

    typedef enum logic {
        AR_IDLE,
        AR_GRANTED
    } ar_state_t;

    ar_state_t         state;
    logic [MST_NB-1:0] grant_r;
    logic [MST_NB-1:0] arb_grant;
    logic              arb_en;
    logic [CNT_W-1:0]  ostd_cnt;
    logic              ar_hs;
    logic              rlast_hs;
    logic [3:0]        route;
    logic [MST_NB-1:0] sel;
    logic              sel_hit;

    //------------------------------------------------------------------
    // AR arbitration
    //------------------------------------------------------------------
    // Arbitration stops while the slave already holds the maximum number
    // of reads, so the counter can never overflow.
    assign arb_en = (state == AR_IDLE) && (ostd_cnt < CNT_W'(OSTDREQ_NUM));

    axicb_round_robin #(
        .REQ_NB        (MST_NB),
        .REQ0_PRIORITY (MST0_PRIORITY),
        .REQ1_PRIORITY (MST1_PRIORITY),
        .REQ2_PRIORITY (MST2_PRIORITY),
        .REQ3_PRIORITY (MST3_PRIORITY)
    ) u_arbiter (
        .aclk  (aclk),
        .srst  (srst),
        .en    (arb_en),
        .req   (i_arvalid),
        .grant (arb_grant)
    );

    always_ff @(posedge aclk) begin
        if (srst) begin
            state   <= AR_IDLE;
            grant_r <= '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (arb_en && |i_arvalid) begin
                        grant_r <= arb_grant;
                        state   <= AR_GRANTED;
                    end
                end
                AR_GRANTED: begin
                    if (ar_hs) begin
                        grant_r <= '0;
                        state   <= AR_IDLE;
                    end
                end
                default: begin
                    grant_r <= '0;
                    state   <= AR_IDLE;
                end
            endcase
        end
    end

    // Granted master is connected straight through; idle drives zeros.
    always_comb begin
        o_arvalid = 1'b0;
        o_arch    = '0;
        i_arready = '0;
        if (state == AR_GRANTED) begin
            for (int i = 0; i < MST_NB; i++) begin
                if (grant_r[i]) begin
                    o_arvalid    = i_arvalid[i];
                    o_arch       = i_arch[i*ARCH_W +: ARCH_W];
                    i_arready[i] = o_arready;
                end
            end
        end
    end

    assign ar_hs = o_arvalid & o_arready;

    //------------------------------------------------------------------
    // Outstanding read counter: one unit per burst, released on rlast
    //------------------------------------------------------------------
    assign rlast_hs = o_rvalid & o_rready & o_rlast;

    always_ff @(posedge aclk) begin
        if (srst)
            ostd_cnt <= '0;
        else if (ar_hs && !rlast_hs)
            ostd_cnt <= ostd_cnt + 1'b1;
        else if (!ar_hs && rlast_hs && ostd_cnt != '0)
            ostd_cnt <= ostd_cnt - 1'b1;
    end

    //------------------------------------------------------------------
    // R routing by RID
    //------------------------------------------------------------------
    assign route = rid_route(32'(o_rch[AXI_ID_W-1:0]),
                             32'(MST0_ID_MASK), 32'(MST1_ID_MASK),
                             32'(MST2_ID_MASK), 32'(MST3_ID_MASK),
                             MST_NB);
    assign sel     = route[MST_NB-1:0];
    assign sel_hit = |sel;

    assign i_rvalid = {MST_NB{o_rvalid}} & sel;
    assign i_rlast  = o_rlast;
    assign i_rch    = o_rch;
    // A beat nobody owns is swallowed so the slave cannot stall forever.
    assign o_rready = sel_hit ? |(sel & i_rready) : 1'b1;

endmodule

// File: tb/tb_axicb_mst_switch_rd.sv
// Self-checking bench for the slave-side read switch.
// Drives randomized AR/R traffic and compares against a queue/arithmetic reference.
// Reference: rotating grant order, outstanding count = ARs - rlasts (floored at 0), lowest matching tag owns an RID.
module tb_axicb_mst_switch_rd;

    localparam int OSTD = 2;

    logic        aclk = 1'b0;
    logic        srst;
    logic [3:0]  i_arvalid;
    logic [3:0]  i_arready;
    logic [31:0] i_arch;
    logic [3:0]  i_rvalid;
    logic [3:0]  i_rready;
    logic        i_rlast;
    logic [15:0] i_rch;
    logic        o_arvalid;
    logic        o_arready;
    logic [7:0]  o_arch;
    logic        o_rvalid;
    logic        o_rready;
    logic        o_rlast;
    logic [15:0] o_rch;

    int errors = 0;
    int checks = 0;
    int masks [4] = '{'h10, 'h20, 'h30, 'h40};

    axicb_mst_switch_rd #(
        .AXI_ID_W    (8),
        .MST_NB      (4),
        .OSTDREQ_NUM (OSTD),
        .ARCH_W      (8),
        .RCH_W       (16)
    ) dut (
        .aclk      (aclk),
        .srst      (srst),
        .i_arvalid (i_arvalid),
        .i_arready (i_arready),
        .i_arch    (i_arch),
        .i_rvalid  (i_rvalid),
        .i_rready  (i_rready),
        .i_rlast   (i_rlast),
        .i_rch     (i_rch),
        .o_arvalid (o_arvalid),
        .o_arready (o_arready),
        .o_arch    (o_arch),
        .o_rvalid  (o_rvalid),
        .o_rready  (o_rready),
        .o_rlast   (o_rlast),
        .o_rch     (o_rch)
    );

    always #5 aclk = ~aclk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Owner of an RID: lowest master whose every tag bit is present in the ID.
    function automatic int exp_owner(input int rid);
        for (int i = 0; i < 4; i++)
            if ((rid & masks[i]) == masks[i])
                return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        srst      = 1'b1;
        i_arvalid = '0;
        i_arch    = '0;
        i_rready  = '0;
        o_arready = 1'b0;
        o_rvalid  = 1'b0;
        o_rlast   = 1'b0;
        o_rch     = '0;
        tick();
        tick();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++; if (o_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %0b exp 0", o_arvalid); end
        checks++; if (i_arready !== 4'b0) begin errors++; $display("FAIL reset_arready: got %0h exp 0", i_arready); end
        checks++; if (o_arch !== 8'h00) begin errors++; $display("FAIL reset_arch: got %0h exp 0", o_arch); end
        checks++; if (dut.ostd_cnt !== 2'd0) begin errors++; $display("FAIL reset_ostd: got %0d exp 0", dut.ostd_cnt); end
        checks++; if (o_rready !== 1'b1) begin errors++; $display("FAIL reset_rready: got %0b exp 1", o_rready); end
    endtask

    task automatic test_single();
        logic [7:0] pay;
        do_reset();
        pay       = 8'($urandom);
        o_arready = 1'b1;
        i_arch[7:0] = pay;
        i_arvalid = 4'b0001;
        settle();
        checks++; if (o_arvalid !== 1'b0) begin errors++; $display("FAIL single_cycle_n: got %0b exp 0", o_arvalid); end
        tick();
        checks++; if (o_arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid: got %0b exp 1", o_arvalid); end
        checks++; if (o_arch !== pay) begin errors++; $display("FAIL single_arch: got %0h exp %0h", o_arch, pay); end
        checks++; if (i_arready !== 4'b0001) begin errors++; $display("FAIL single_arready: got %0h exp 1", i_arready); end
        tick();
        i_arvalid = '0;
        settle();
        checks++; if (dut.ostd_cnt !== 2'd1) begin errors++; $display("FAIL single_ostd1: got %0d exp 1", dut.ostd_cnt); end
        o_rvalid = 1'b1;
        o_rlast  = 1'b1;
        o_rch    = {8'($urandom), 8'h10};
        i_rready = 4'b0001;
        settle();
        checks++; if (i_rvalid !== 4'b0001) begin errors++; $display("FAIL single_rvalid: got %0h exp 1", i_rvalid); end
        checks++; if (o_rready !== 1'b1) begin errors++; $display("FAIL single_rready: got %0b exp 1", o_rready); end
        tick();
        o_rvalid = 1'b0;
        o_rlast  = 1'b0;
        settle();
        checks++; if (dut.ostd_cnt !== 2'd0) begin errors++; $display("FAIL single_ostd0: got %0d exp 0", dut.ostd_cnt); end
    endtask

    // All masters request continuously; unowned rlast beats every cycle keep
    // the outstanding count from blocking the rotation.
    task automatic test_round_robin();
        logic [7:0] pays [4];
        int exp_last = 3;
        int prev_c   = -1;
        int nhs      = 0;
        int hs_m     = -1;
        do_reset();
        for (int m = 0; m < 4; m++) begin
            pays[m] = 8'($urandom);
            i_arch[m*8 +: 8] = pays[m];
        end
        o_arready = 1'b1;
        o_rvalid  = 1'b1;
        o_rlast   = 1'b1;
        o_rch     = 16'h0005;
        i_arvalid = 4'hF;
        for (int c = 0; c < 40 && nhs < 8; c++) begin
            settle();
            hs_m = -1;
            if (o_arvalid && o_arready) begin
                int exp_m;
                exp_m = (exp_last + 1) % 4;
                checks++; if (i_arready !== 4'(1 << exp_m)) begin errors++; $display("FAIL rr_grant: got %0h exp %0h", i_arready, 4'(1 << exp_m)); end
                checks++; if (o_arch !== pays[exp_m]) begin errors++; $display("FAIL rr_arch: got %0h exp %0h", o_arch, pays[exp_m]); end
                checks++;
                if ((prev_c < 0 && c != 1) || (prev_c >= 0 && c - prev_c != 2)) begin
                    errors++; $display("FAIL rr_spacing: got cycle %0d exp %0d", c, (prev_c < 0) ? 1 : prev_c + 2);
                end
                prev_c   = c;
                exp_last = exp_m;
                hs_m     = exp_m;
                nhs++;
            end
            tick();
            if (hs_m >= 0) begin
                pays[hs_m] = 8'($urandom);
                i_arch[hs_m*8 +: 8] = pays[hs_m];
            end
        end
        checks++; if (nhs != 8) begin errors++; $display("FAIL rr_count: got %0d exp 8", nhs); end
        i_arvalid = '0;
        o_rvalid  = 1'b0;
        o_rlast   = 1'b0;
        settle();
        checks++; if (dut.ostd_cnt !== 2'd0) begin errors++; $display("FAIL rr_ostd: got %0d exp 0", dut.ostd_cnt); end
    endtask

    task automatic test_ostd_limit();
        logic [7:0] pays [4];
        int  nhs   = 0;
        bit  found = 0;
        do_reset();
        for (int m = 0; m < 4; m++) begin
            pays[m] = 8'($urandom);
            i_arch[m*8 +: 8] = pays[m];
        end
        o_arready = 1'b1;
        i_arvalid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (o_arvalid && o_arready) nhs++;
            tick();
        end
        settle();
        checks++; if (nhs != OSTD) begin errors++; $display("FAIL limit_ars: got %0d exp %0d", nhs, OSTD); end
        checks++; if (o_arvalid !== 1'b0) begin errors++; $display("FAIL limit_blocked: got %0b exp 0", o_arvalid); end
        checks++; if (dut.ostd_cnt !== 2'(OSTD)) begin errors++; $display("FAIL limit_ostd: got %0d exp %0d", dut.ostd_cnt, OSTD); end
        o_rvalid = 1'b1;
        o_rlast  = 1'b1;
        o_rch    = 16'h0010;
        i_rready = 4'b0001;
        tick();
        o_rvalid = 1'b0;
        o_rlast  = 1'b0;
        for (int c = 0; c < 3 && !found; c++) begin
            settle();
            if (o_arvalid) found = 1;
            else tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL limit_resume: got no AR exp AR within 2 cycles"); end
        checks++; if (i_arready !== 4'b0100) begin errors++; $display("FAIL limit_grant: got %0h exp 4", i_arready); end
        checks++; if (o_arch !== pays[2]) begin errors++; $display("FAIL limit_arch: got %0h exp %0h", o_arch, pays[2]); end
        tick();
        i_arvalid = '0;
    endtask

    task automatic test_r_burst();
        int         lo   = $urandom_range(0, 2);
        int         beat = 0;
        logic [7:0] data;
        logic       rdy1;
        do_reset();
        for (int c = 0; c < 12 && beat < 4; c++) begin
            data     = 8'($urandom);
            rdy1     = !(c == lo || c == lo + 1);
            o_rvalid = 1'b1;
            o_rch    = {data, 8'h23};
            o_rlast  = (beat == 3);
            i_rready = 4'($urandom_range(0, 15));
            i_rready[1] = rdy1;
            settle();
            checks++; if (i_rvalid !== 4'b0010) begin errors++; $display("FAIL burst_rvalid: got %0h exp 2", i_rvalid); end
            checks++; if (o_rready !== rdy1) begin errors++; $display("FAIL burst_rready: got %0b exp %0b", o_rready, rdy1); end
            checks++; if (i_rlast !== (beat == 3)) begin errors++; $display("FAIL burst_rlast: got %0b exp %0b at beat %0d", i_rlast, beat == 3, beat); end
            checks++; if (i_rch !== {data, 8'h23}) begin errors++; $display("FAIL burst_rch: got %0h exp %0h", i_rch, {data, 8'h23}); end
            tick();
            if (rdy1) beat++;
        end
        o_rvalid = 1'b0;
        o_rlast  = 1'b0;
        settle();
        checks++; if (beat != 4) begin errors++; $display("FAIL burst_beats: got %0d exp 4", beat); end
        checks++; if (dut.ostd_cnt !== 2'd0) begin errors++; $display("FAIL burst_ostd: got %0d exp 0", dut.ostd_cnt); end
    endtask

    task automatic test_no_match();
        bit ok = 0;
        do_reset();
        o_arready = 1'b1;
        i_arch[31:24] = 8'($urandom);
        i_arvalid = 4'b1000;
        for (int c = 0; c < 4 && !ok; c++) begin
            settle();
            if (o_arvalid && o_arready) ok = 1;
            tick();
        end
        i_arvalid = '0;
        settle();
        checks++; if (!ok) begin errors++; $display("FAIL nomatch_ar: got no handshake exp handshake"); end
        checks++; if (dut.ostd_cnt !== 2'd1) begin errors++; $display("FAIL nomatch_ostd1: got %0d exp 1", dut.ostd_cnt); end
        o_arready = 1'b0;
        i_arvalid = 4'b1000;
        tick();
        settle();
        checks++; if (o_arvalid !== 1'b1) begin errors++; $display("FAIL nomatch_granted: got %0b exp 1", o_arvalid); end
        o_arready = 1'b1;
        o_rvalid  = 1'b1;
        o_rlast   = 1'b1;
        o_rch     = {8'($urandom), 8'h05};
        i_rready  = 4'b0000;
        settle();
        checks++; if (o_rready !== 1'b1) begin errors++; $display("FAIL nomatch_rready: got %0b exp 1", o_rready); end
        checks++; if (i_rvalid !== 4'b0000) begin errors++; $display("FAIL nomatch_rvalid: got %0h exp 0", i_rvalid); end
        tick();
        i_arvalid = '0;
        o_rvalid  = 1'b0;
        o_rlast   = 1'b0;
        settle();
        checks++; if (dut.ostd_cnt !== 2'd1) begin errors++; $display("FAIL simul_ostd: got %0d exp 1", dut.ostd_cnt); end
        o_rvalid = 1'b1;
        o_rlast  = 1'b1;
        tick();
        o_rvalid = 1'b0;
        o_rlast  = 1'b0;
        settle();
        checks++; if (dut.ostd_cnt !== 2'd0) begin errors++; $display("FAIL nomatch_dec: got %0d exp 0", dut.ostd_cnt); end
    endtask

    task automatic test_random_route();
        int         model_ostd = 0;
        int         rid;
        int         own;
        logic [7:0] data;
        logic [3:0] exp_rv;
        logic       exp_rr;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            rid      = $urandom_range(0, 255);
            data     = 8'($urandom);
            o_rch    = {data, 8'(rid)};
            o_rvalid = 1'($urandom_range(0, 1));
            o_rlast  = 1'($urandom_range(0, 1));
            i_rready = 4'($urandom_range(0, 15));
            settle();
            own    = exp_owner(rid);
            exp_rv = (own >= 0 && o_rvalid) ? 4'(1 << own) : 4'b0;
            exp_rr = (own >= 0) ? i_rready[own] : 1'b1;
            checks++; if (i_rvalid !== exp_rv) begin errors++; $display("FAIL route_rvalid: rid %0h got %0h exp %0h", rid, i_rvalid, exp_rv); end
            checks++; if (o_rready !== exp_rr) begin errors++; $display("FAIL route_rready: rid %0h got %0b exp %0b", rid, o_rready, exp_rr); end
            checks++; if (i_rlast !== o_rlast || i_rch !== {data, 8'(rid)}) begin errors++; $display("FAIL route_bcast: got %0b/%0h exp %0b/%0h", i_rlast, i_rch, o_rlast, {data, 8'(rid)}); end
            if (o_rvalid && exp_rr && o_rlast && model_ostd > 0) model_ostd--;
            tick();
        end
        o_rvalid = 1'b0;
        settle();
        checks++; if (dut.ostd_cnt !== 2'(model_ostd)) begin errors++; $display("FAIL route_ostd: got %0d exp %0d", dut.ostd_cnt, model_ostd); end
    endtask

    task automatic test_srst();
        bit         ok = 0;
        logic [7:0] pay;
        do_reset();
        o_arready = 1'b1;
        i_arvalid = 4'b0001;
        for (int c = 0; c < 4 && !ok; c++) begin
            settle();
            if (o_arvalid && o_arready) ok = 1;
            tick();
        end
        i_arvalid = '0;
        settle();
        checks++; if (!ok || dut.ostd_cnt !== 2'd1) begin errors++; $display("FAIL srst_setup: got ok=%0b ostd=%0d exp ok=1 ostd=1", ok, dut.ostd_cnt); end
        pay = 8'($urandom);
        i_arch[23:16] = pay;
        i_arvalid = 4'b0100;
        o_arready = 1'b0;
        tick();
        settle();
        checks++; if (o_arvalid !== 1'b1) begin errors++; $display("FAIL srst_granted: got %0b exp 1", o_arvalid); end
        srst = 1'b1;
        tick();
        settle();
        checks++; if (o_arvalid !== 1'b0) begin errors++; $display("FAIL srst_arvalid: got %0b exp 0", o_arvalid); end
        checks++; if (dut.ostd_cnt !== 2'd0) begin errors++; $display("FAIL srst_ostd: got %0d exp 0", dut.ostd_cnt); end
        srst = 1'b0;
        tick();
        settle();
        checks++; if (o_arvalid !== 1'b1 || o_arch !== pay) begin errors++; $display("FAIL srst_restart: got %0b/%0h exp 1/%0h", o_arvalid, o_arch, pay); end
        o_arready = 1'b1;
        tick();
        i_arvalid = '0;
        o_arready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ostd_limit();
        test_r_burst();
        test_no_match();
        test_random_route();
        test_srst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axicb_mst_switch_rd.md
# axicb_mst_switch_rd

Slave-side read switch of the crossbar: one instance per slave agent. Arbitrates the read address channels of up to four master switches onto the single slave AR interface and routes read data completions back to the originating master by decoding the RID. Also bounds the number of outstanding read requests toward the slave.

## Interface

Parameters:
- AXI_ID_W, 8, ID width in bits; RID occupies o_rch[AXI_ID_W-1:0].
- MST_NB, 4, number of masters; 1 to 4 supported.
- MST0_ID_MASK .. MST3_ID_MASK, 'h10/'h20/'h30/'h40, per-master ID tag; RID belongs to master i when (RID & MSTi_ID_MASK) == MSTi_ID_MASK.
- MST0_PRIORITY .. MST3_PRIORITY, 0, arbiter priority level per master, passed to axicb_round_robin.
- OSTDREQ_NUM, 4, max outstanding read requests (1..255).
- ARCH_W, 8, concatenated AR channel width.
- RCH_W, 8, concatenated R channel width.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- srst  in  1  reset, synchronous, active-high.
- i_arvalid  in  MST_NB  per-master AR valid.
- i_arready  out  MST_NB  per-master AR ready.
- i_arch  in  MST_NB*ARCH_W  per-master AR payload; master i at [i*ARCH_W+:ARCH_W].
- i_rvalid  out  MST_NB  per-master R valid.
- i_rready  in  MST_NB  per-master R ready.
- i_rlast  out  1  R last, broadcast.
- i_rch  out  RCH_W  R payload, broadcast.
- o_arvalid  out  1  AR valid to slave.
- o_arready  in  1  AR ready from slave.
- o_arch  out  ARCH_W  AR payload to slave.
- o_rvalid  in  1  R valid from slave.
- o_rready  out  1  R ready to slave.
- o_rlast  in  1  R last from slave.
- o_rch  in  RCH_W  R payload from slave.

## Operation

- AR FSM, two states, reset IDLE:
  - IDLE: if any i_arvalid and ostd_cnt < OSTDREQ_NUM, enable arbiter; register its one-hot grant into grant_r and go to GRANTED. Otherwise stay.
  - GRANTED: o_arvalid = i_arvalid[g], o_arch = i_arch of g, i_arready[g] = o_arready, all other i_arready = 0. On o_arvalid & o_arready, clear grant_r and return to IDLE.
- Arbiter enabled only in IDLE with ostd_cnt < OSTDREQ_NUM; requests come from i_arvalid, gated by MST_NB.
- In IDLE: o_arvalid = 0, all i_arready = 0, o_arch = 0.
- Outstanding counter ostd_cnt, width $clog2(OSTDREQ_NUM+1):
  - +1 on an AR handshake; -1 on an R handshake with o_rlast; unchanged when both occur in the same cycle.
  - Saturates at 0 on decrement. Never exceeds OSTDREQ_NUM because arbitration is blocked at the limit.
- R routing is combinational on RID = o_rch[AXI_ID_W-1:0]:
  - sel[i] = mask match for i < MST_NB; the lowest matching index wins (one-hot).
  - i_rvalid[i] = o_rvalid & sel[i]; i_rch = o_rch; i_rlast = o_rlast.
  - o_rready = |(sel & i_rready) when a match exists.
  - No match: o_rready = 1; the beat is consumed and dropped, and ostd_cnt still decrements on rlast.
- The slave interleaves no bursts, so no burst lock is needed beyond RID stability.

## Timing

- Reset values: state IDLE, grant_r 0, ostd_cnt 0. Hence o_arvalid 0, i_arready all 0, o_arch 0. R outputs follow their inputs combinationally.
- AR latency: i_arvalid at cycle N gives o_arvalid at N+1. The earliest handshake is at N+1; the next grant is registered at N+2 and valid at N+3. Peak rate is one AR per 2 cycles.
- R path: zero latency; no register between o_r* and i_r*.
- AXI valid/ready rules are relied upon: masters keep i_arvalid and payload stable until handshake.
- srst mid-operation: FSM, grant and counter clear in the next cycle. Late completions are still routed by ID; the counter stays at 0.

## Structure

- Shared package axicb_pkg holds the RID routing function (mask-match) and the ostd counter width function. Both are reused by the write-side twin.
- Sub-module: existing axicb_round_robin (REQ_NB = MST_NB, REQx_PRIORITY from parameters).
- FSM encoding is a local enum; there are no other sub-modules.

## Test plan

- Single master 0 issues AR with o_arready held 1 -> o_arvalid rises 1 cycle later, handshake occurs, ostd_cnt = 1. R beat with RID 'h10 and rlast -> i_rvalid[0] = 1, ostd_cnt returns to 0.
- Masters 0..3 request continuously, equal priority -> grants in rotating order 0,1,2,3,0 with one AR every 2 cycles.
- OSTDREQ_NUM = 2, no R returned -> after 2 ARs, o_arvalid stays 0. One rlast handshake -> next AR is granted within 2 cycles.
- R burst of 4 beats, RID 'h23, master 1 deasserts i_rready for 2 cycles -> o_rready follows i_rready[1]; only i_rvalid[1] is asserted; i_rlast occurs on beat 4.
- RID 'h05 (no match), rlast -> o_rready = 1, no i_rvalid bit set, ostd_cnt decrements. Simultaneous AR handshake and rlast -> count unchanged.
- srst pulsed while GRANTED with o_arready 0 -> next cycle o_arvalid = 0, ostd_cnt = 0, and the arbiter restarts on the pending i_arvalid.
